updown_cnt_cascade: RTL and testbench

//   Parametrised synchronous up/down counter with parallel load, enable, and

---
 rtl/updown_cnt_cascade_if.sv | 34 +++
 rtl/updown_cnt_cascade.sv | 78 +++++++
 tb/tb_updown_cnt_cascade.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_cnt_cascade_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_cnt_cascade_if
// Purpose  : Control/status bundle of one up/down counter stage. The compare
//            signals exist only when CNT_CMP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface updown_cnt_cascade_if #(
   parameter int WIDTH = 8
);
   logic             pl;
   logic [WIDTH-1:0] din;
   logic             en;
   logic             up;
   logic             cin_n;
   logic [WIDTH-1:0] dout;
   logic             tc;
   logic             cout_n;
`ifdef CNT_CMP_EN
   logic [WIDTH-1:0] cmp_val;
   logic             cmp_hit;

   modport master (output pl, din, en, up, cin_n, cmp_val,
                   input  dout, tc, cout_n, cmp_hit);
   modport slave  (input  pl, din, en, up, cin_n, cmp_val,
                   output dout, tc, cout_n, cmp_hit);
`else
   modport master (output pl, din, en, up, cin_n,
                   input  dout, tc, cout_n);
   modport slave  (input  pl, din, en, up, cin_n,
                   output dout, tc, cout_n);
`endif
endinterface
`default_nettype wire

// File: rtl/updown_cnt_cascade.sv
`default_nettype none
// ============================================================================
// Module   : updown_cnt_cascade
// Purpose  : Cascadable up/down counter with load, enable, active-low carry
//            chain and wrap/saturate mode. Optional compare: CNT_CMP_EN.
// Revision : 1.0  initial release
// ============================================================================
module updown_cnt_cascade #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH - 1,
   parameter bit SATURATE = 1'b0
) (
   input  wire logic            clk,
   input  wire logic            reset,
   updown_cnt_cascade_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] load_val;
   logic             act;
   logic             term;

   assign act  = bus.en & ~bus.cin_n;
   assign term = bus.up ? (count_q == MAX_V) : (count_q == '0);

   assign bus.dout   = count_q;
   assign bus.tc     = term;
   assign bus.cout_n = ~(act & term);

   // A full-range counter cannot receive an out-of-range load value.
   generate
      if (MAX_VAL == 2**WIDTH - 1) begin : g_no_clamp
         assign load_val = bus.din;
      end else begin : g_clamp
         assign load_val = (bus.din > MAX_V) ? MAX_V : bus.din;
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      if (bus.pl) begin
         count_d = load_val;
      end else if (act) begin
         if (!term) begin
            count_d = bus.up ? (count_q + 1'b1) : (count_q - 1'b1);
         end else if (!SATURATE) begin
            count_d = bus.up ? '0 : MAX_V;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= bus.up ? '0 : MAX_V;
      end else begin
         count_q <= count_d;
      end
   end

`ifdef CNT_CMP_EN
   logic cmp_hit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_hit_q <= 1'b0;
      end else begin
         cmp_hit_q <= (count_q == bus.cmp_val);
      end
   end

   assign bus.cmp_hit = cmp_hit_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_cnt_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_cnt_cascade
// Purpose  : Scoreboard bench for updown_cnt_cascade (wrap, saturate,
//            reduced range, two-stage cascade, optional CNT_CMP_EN compare).
// Revision : 1.0  initial release
// ============================================================================
module tb_updown_cnt_cascade;

   typedef enum logic [3:0] {
      A_DOUT, A_TC, A_COUT, A_HIT,
      S_DOUT, S_TC,
      W_DOUT, W_COUT,
      C_DOUT, C_LCOUT, C_HCOUT
   } sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      int unsigned exp;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_pl;
   logic       c_en;
   logic       c_up;
   logic [7:0] c_din;
   sb_t        sb_q[$];
   int         n_err = 0;
   int         n_chk = 0;

   always #5 clk = ~clk;

   updown_cnt_cascade_if #(.WIDTH(8)) ia ();
   updown_cnt_cascade_if #(.WIDTH(4)) isat ();
   updown_cnt_cascade_if #(.WIDTH(4)) iwr ();
   updown_cnt_cascade_if #(.WIDTH(4)) il ();
   updown_cnt_cascade_if #(.WIDTH(4)) ih ();

   updown_cnt_cascade #(.WIDTH(8)) u_a (
      .clk(clk), .reset(reset), .bus(ia));
   updown_cnt_cascade #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .bus(isat));
   updown_cnt_cascade #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wr (
      .clk(clk), .reset(reset), .bus(iwr));
   updown_cnt_cascade #(.WIDTH(4)) u_lo (
      .clk(clk), .reset(reset), .bus(il));
   updown_cnt_cascade #(.WIDTH(4)) u_hi (
      .clk(clk), .reset(reset), .bus(ih));

   // Cascade: low stage carry-in tied active, high stage fed by low carry-out
   assign il.cin_n = 1'b0;
   assign ih.cin_n = il.cout_n;
   assign il.en    = c_en;
   assign ih.en    = c_en;
   assign il.up    = c_up;
   assign ih.up    = c_up;
   assign il.pl    = c_pl;
   assign ih.pl    = c_pl;
   assign il.din   = c_din[3:0];
   assign ih.din   = c_din[7:4];
`ifdef CNT_CMP_EN
   assign il.cmp_val = 4'h0;
   assign ih.cmp_val = 4'h0;
`endif

   task automatic check_val(input string tag, input int unsigned act,
                            input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   function automatic int unsigned observe(input sel_e s);
      case (s)
         A_DOUT:  return int'(ia.dout);
         A_TC:    return int'(ia.tc);
         A_COUT:  return int'(ia.cout_n);
`ifdef CNT_CMP_EN
         A_HIT:   return int'(ia.cmp_hit);
`endif
         S_DOUT:  return int'(isat.dout);
         S_TC:    return int'(isat.tc);
         W_DOUT:  return int'(iwr.dout);
         W_COUT:  return int'(iwr.cout_n);
         C_DOUT:  return int'({ih.dout, il.dout});
         C_LCOUT: return int'(il.cout_n);
         C_HCOUT: return int'(ih.cout_n);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_val(input string tag, input sel_e sel,
                             input int unsigned exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   // Advance one clock, then score everything expected after that edge
   task automatic tick();
      sb_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int unsigned cnt_exp[5] = '{1, 2, 3, 4, 5};
      int unsigned hit_exp[5] = '{0, 0, 0, 1, 0};

      reset = 1'b1;
      ia.pl = 1'b0;   ia.din = 8'h00;   ia.en = 1'b0;   ia.up = 1'b1;   ia.cin_n = 1'b0;
      isat.pl = 1'b0; isat.din = 4'h0;  isat.en = 1'b0; isat.up = 1'b1; isat.cin_n = 1'b0;
      iwr.pl = 1'b0;  iwr.din = 4'h0;   iwr.en = 1'b0;  iwr.up = 1'b1;  iwr.cin_n = 1'b0;
      c_pl = 1'b0; c_en = 1'b0; c_up = 1'b1; c_din = 8'h00;
`ifdef CNT_CMP_EN
      ia.cmp_val = 8'h03; isat.cmp_val = 4'h0; iwr.cmp_val = 4'h0;
`endif

      // Reset values
      expect_val("rst_up_a", A_DOUT, 'h00);
      expect_val("rst_up_tc", A_TC, 0);
      expect_val("rst_cout", A_COUT, 1);
      expect_val("rst_sat", S_DOUT, 0);
      expect_val("rst_wr", W_DOUT, 0);
      expect_val("rst_casc", C_DOUT, 'h00);
`ifdef CNT_CMP_EN
      expect_val("rst_hit", A_HIT, 0);
`endif
      tick();
      ia.up = 1'b0;
      expect_val("rst_dn_a", A_DOUT, 'hFF);
      expect_val("rst_dn_tc", A_TC, 0);
      tick();

      // Load ignores en / cin_n
      reset = 1'b0; ia.up = 1'b1; ia.pl = 1'b1; ia.din = 8'h5A; ia.en = 1'b0; ia.cin_n = 1'b1;
      expect_val("load_5a", A_DOUT, 'h5A);
      tick();
      ia.din = 8'h33; ia.en = 1'b1;
      expect_val("load_33", A_DOUT, 'h33);
      tick();
      ia.pl = 1'b0;
      expect_val("hold_cin", A_DOUT, 'h33);
      expect_val("hold_cout", A_COUT, 1);
      tick();

      // Wrap up through 0xFF
      ia.pl = 1'b1; ia.din = 8'hFE; ia.cin_n = 1'b0;
      expect_val("load_fe", A_DOUT, 'hFE);
      tick();
      ia.pl = 1'b0;
      expect_val("up_ff", A_DOUT, 'hFF);
      expect_val("up_ff_tc", A_TC, 1);
      expect_val("up_ff_cout", A_COUT, 0);
      tick();
      ia.en = 1'b0;
      expect_val("hold_ff", A_DOUT, 'hFF);
      expect_val("hold_ff_tc", A_TC, 1);
      expect_val("hold_ff_cout", A_COUT, 1);
      tick();
      ia.en = 1'b1;
      expect_val("wrap_00", A_DOUT, 'h00);
      expect_val("wrap_00_tc", A_TC, 0);
      expect_val("wrap_00_cout", A_COUT, 1);
      tick();

      // Down through zero
      ia.pl = 1'b1; ia.din = 8'h01; ia.up = 1'b0;
      expect_val("load_01", A_DOUT, 'h01);
      tick();
      ia.pl = 1'b0;
      expect_val("dn_00", A_DOUT, 'h00);
      expect_val("dn_00_tc", A_TC, 1);
      expect_val("dn_00_cout", A_COUT, 0);
      tick();
      expect_val("dn_wrap", A_DOUT, 'hFF);
      expect_val("dn_wrap_tc", A_TC, 0);
      tick();

      // Load beats count; reset beats count
      ia.pl = 1'b1; ia.din = 8'h20; ia.up = 1'b1;
      expect_val("prio_load", A_DOUT, 'h20);
      tick();
      ia.pl = 1'b0;
      expect_val("after_load", A_DOUT, 'h21);
      tick();
      reset = 1'b1;
      expect_val("rst_mid", A_DOUT, 'h00);
`ifdef CNT_CMP_EN
      expect_val("rst_mid_hit", A_HIT, 0);
`endif
      tick();
      reset = 1'b0;

      // Count from zero; registered compare lags dout by one cycle
      for (int i = 0; i < 5; i++) begin
         expect_val("cnt_seq", A_DOUT, cnt_exp[i]);
`ifdef CNT_CMP_EN
         expect_val("hit_seq", A_HIT, hit_exp[i]);
`else
         if (hit_exp[i] > 1) expect_val("hit_none", A_DOUT, 0);
`endif
         tick();
      end
`ifdef CNT_CMP_EN
      ia.pl = 1'b1; ia.din = 8'h03; ia.en = 1'b0;
      expect_val("hit_ld3", A_HIT, 0);
      tick();
      ia.pl = 1'b0;
      expect_val("hit_hold3", A_HIT, 1);
      tick();
      ia.pl = 1'b1; ia.din = 8'h20; ia.en = 1'b1;
      expect_val("hit_pl_en", A_DOUT, 'h20);
      expect_val("hit_kept", A_HIT, 1);
      tick();
      ia.pl = 1'b0; ia.en = 1'b0;
      expect_val("hit_clr", A_HIT, 0);
      tick();
`endif

      // Saturating counter, range 0..9
      isat.pl = 1'b1; isat.din = 4'd7;
      expect_val("sat_ld7", S_DOUT, 7);
      tick();
      isat.pl = 1'b0; isat.en = 1'b1;
      expect_val("sat_8", S_DOUT, 8);
      expect_val("sat_8_tc", S_TC, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_val("sat_9", S_DOUT, 9);
         expect_val("sat_9_tc", S_TC, 1);
         tick();
      end
      isat.pl = 1'b1; isat.din = 4'd12;
      expect_val("sat_clamp", S_DOUT, 9);
      tick();
      isat.din = 4'd0;
      expect_val("sat_ld0", S_DOUT, 0);
      tick();
      isat.pl = 1'b0; isat.up = 1'b0;
      expect_val("sat_dn0", S_DOUT, 0);
      expect_val("sat_dn0_tc", S_TC, 1);
      tick();

      // Wrapping counter, range 0..9
      iwr.pl = 1'b1; iwr.din = 4'd1; iwr.up = 1'b0; iwr.en = 1'b1;
      expect_val("wr_ld1", W_DOUT, 1);
      tick();
      iwr.pl = 1'b0;
      expect_val("wr_0", W_DOUT, 0);
      expect_val("wr_0_cout", W_COUT, 0);
      tick();
      expect_val("wr_9", W_DOUT, 9);
      expect_val("wr_9_cout", W_COUT, 1);
      tick();
      expect_val("wr_8", W_DOUT, 8);
      tick();
      iwr.up = 1'b1;
      expect_val("wr_up9", W_DOUT, 9);
      expect_val("wr_up9_cout", W_COUT, 0);
      tick();
      expect_val("wr_up0", W_DOUT, 0);
      expect_val("wr_up0_cout", W_COUT, 1);
      tick();

      // Two 4-bit stages cascaded into 8 bits
      c_pl = 1'b1; c_din = 8'h0E;
      expect_val("cas_ld", C_DOUT, 'h0E);
      tick();
      c_pl = 1'b0; c_en = 1'b1;
      expect_val("cas_0f", C_DOUT, 'h0F);
      expect_val("cas_0f_lc", C_LCOUT, 0);
      expect_val("cas_0f_hc", C_HCOUT, 1);
      tick();
      expect_val("cas_10", C_DOUT, 'h10);
      expect_val("cas_10_lc", C_LCOUT, 1);
      tick();
      expect_val("cas_11", C_DOUT, 'h11);
      tick();
      c_pl = 1'b1; c_din = 8'hFF;
      expect_val("cas_ldff", C_DOUT, 'hFF);
      expect_val("cas_ff_hc", C_HCOUT, 0);
      tick();
      c_pl = 1'b0;
      expect_val("cas_wrap", C_DOUT, 'h00);
      tick();
      c_up = 1'b0;
      expect_val("cas_dn", C_DOUT, 'hFF);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
